// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions: datapath widths, ALU operation codes
//               and operand forward-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_XNOR = 4'hA;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/ex_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : ex_fwd_sel
// Description : Forward select for one EX operand. Compares the operand's
//               source index against the MEM and WB destinations and picks
//               MEM result, WB result or the register-file value (MEM wins).
//               Register 0 is never forwarded.
//               Build macro EX_FWD_EN enables forwarding; without it the
//               register value always passes through.
// Ports       : src_idx/reg_data   - operand index and register-file value
//               m_idx/m_we/m_data  - MEM-stage destination, enable, result
//               w_idx/w_we/w_data  - WB-stage destination, enable, result
//               fwd_data           - selected operand
// Revision    : 1.0 - initial release
// ============================================================================
module ex_fwd_sel
  import cpu_pkg::fwd_sel_e, cpu_pkg::FWD_REG, cpu_pkg::FWD_W, cpu_pkg::FWD_M;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src_idx,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [REG_AW-1:0] m_idx,
  input  logic              m_we,
  input  logic [DATA_W-1:0] m_data,
  input  logic [REG_AW-1:0] w_idx,
  input  logic              w_we,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] fwd_data
);

`ifdef EX_FWD_EN
  fwd_sel_e w_sel;

  always_comb begin
    w_sel = FWD_REG;
    if (m_we && (m_idx != '0) && (m_idx == src_idx)) begin
      w_sel = FWD_M;
    end else if (w_we && (w_idx != '0) && (w_idx == src_idx)) begin
      w_sel = FWD_W;
    end
  end

  always_comb begin
    fwd_data = reg_data;
    case (w_sel)
      FWD_M:   fwd_data = m_data;
      FWD_W:   fwd_data = w_data;
      default: fwd_data = reg_data;
    endcase
  end
`else
  // Forwarding compiled out: the hazard unit stalls on every RAW dependence.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{src_idx, m_idx, m_we, m_data, w_idx, w_we, w_data};
  assign fwd_data     = reg_data;
`endif

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_operand_stage
// Description : ID/EX pipeline register with EX-stage operand forwarding.
//               Feeds the ALU (ALUsel, Shamt, ALUIn1, ALUIn2) and carries
//               store data and write-back control towards EX/MEM.
//               Build macro EX_FWD_EN enables MEM/WB forwarding.
// Ports       : clk, rst (sync, active-high), StallE, FlushE
//               D-stage inputs  : RD1D, RD2D, SignImmD, RsD, RtD, WriteRegD,
//                                 ALUSelD, ShamtD, ALUSrcD, RegWriteD,
//                                 MemWriteD, MemtoRegD
//               Forward sources : ALUOutM, WriteRegM, RegWriteM,
//                                 ResultW, WriteRegW, RegWriteW
//               E-stage outputs : ALUsel, Shamt, ALUIn1, ALUIn2, WriteDataE,
//                                 WriteRegE, RsE, RtE, RegWriteE, MemWriteE,
//                                 MemtoRegE, ValidE
// Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage
  import cpu_pkg::ALU_ADD;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic [3:0]        ALUSelD,
  input  logic [4:0]        ShamtD,
  input  logic              ALUSrcD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              MemtoRegD,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteM,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteW,
  output logic [3:0]        ALUsel,
  output logic [4:0]        Shamt,
  output logic [DATA_W-1:0] ALUIn1,
  output logic [DATA_W-1:0] ALUIn2,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [REG_AW-1:0] WriteRegE,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              MemtoRegE,
  output logic              ValidE
);

  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_wreg;
  logic [3:0]        r_alusel;
  logic [4:0]        r_shamt;
  logic              r_alusrc;
  logic              r_regwrite;
  logic              r_memwrite;
  logic              r_memtoreg;
  logic              r_valid;

  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  // Reset and flush both produce the same all-zero canonical bubble;
  // either one overrides a stall.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wreg     <= '0;
      r_alusel   <= ALU_ADD;
      r_shamt    <= '0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_valid    <= 1'b0;
    end else if (!StallE) begin
      r_rd1      <= RD1D;
      r_rd2      <= RD2D;
      r_imm      <= SignImmD;
      r_rs       <= RsD;
      r_rt       <= RtD;
      r_wreg     <= WriteRegD;
      r_alusel   <= ALUSelD;
      r_shamt    <= ShamtD;
      r_alusrc   <= ALUSrcD;
      r_regwrite <= RegWriteD;
      r_memwrite <= MemWriteD;
      r_memtoreg <= MemtoRegD;
      r_valid    <= 1'b1;
    end
  end

  ex_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_idx  (r_rs),
    .reg_data (r_rd1),
    .m_idx    (WriteRegM),
    .m_we     (RegWriteM),
    .m_data   (ALUOutM),
    .w_idx    (WriteRegW),
    .w_we     (RegWriteW),
    .w_data   (ResultW),
    .fwd_data (w_fwd_a)
  );

  ex_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_idx  (r_rt),
    .reg_data (r_rd2),
    .m_idx    (WriteRegM),
    .m_we     (RegWriteM),
    .m_data   (ALUOutM),
    .w_idx    (WriteRegW),
    .w_we     (RegWriteW),
    .w_data   (ResultW),
    .fwd_data (w_fwd_b)
  );

  // Store data always takes the forwarded rt value, even when the ALU
  // itself is using the immediate.
  assign ALUIn1     = w_fwd_a;
  assign WriteDataE = w_fwd_b;
  assign ALUIn2     = r_alusrc ? r_imm : w_fwd_b;

  assign ALUsel     = r_alusel;
  assign Shamt      = r_shamt;
  assign WriteRegE  = r_wreg;
  assign RsE        = r_rs;
  assign RtE        = r_rt;
  assign RegWriteE  = r_regwrite;
  assign MemWriteE  = r_memwrite;
  assign MemtoRegE  = r_memtoreg;
  assign ValidE     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_operand_stage
// Description : Self-checking bench for ex_operand_stage. Directed cases
//               followed by randomized stall/flush/reset/forward traffic,
//               compared against a behavioural pipeline-register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, WriteRegD;
  logic [3:0]  ALUSelD;
  logic [4:0]  ShamtD;
  logic        ALUSrcD, RegWriteD, MemWriteD, MemtoRegD;
  logic [31:0] ALUOutM, ResultW;
  logic [4:0]  WriteRegM, WriteRegW;
  logic        RegWriteM, RegWriteW;
  logic [3:0]  ALUsel;
  logic [4:0]  Shamt;
  logic [31:0] ALUIn1, ALUIn2, WriteDataE;
  logic [4:0]  WriteRegE, RsE, RtE;
  logic        RegWriteE, MemWriteE, MemtoRegE, ValidE;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD),
    .ALUSelD(ALUSelD), .ShamtD(ShamtD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .ALUsel(ALUsel), .Shamt(Shamt), .ALUIn1(ALUIn1), .ALUIn2(ALUIn2),
    .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .RsE(RsE), .RtE(RtE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .ValidE(ValidE)
  );

  // Reference model: the E-stage content as an instruction record.
  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, wreg, shamt;
    logic [3:0]  alusel;
    logic        alusrc, regwrite, memwrite, memtoreg, valid;
  } e_rec_t;

  e_rec_t m_e;

  function automatic e_rec_t bubble();
    e_rec_t b;
    b.rd1 = 0; b.rd2 = 0; b.imm = 0; b.rs = 0; b.rt = 0; b.wreg = 0;
    b.shamt = 0; b.alusel = 0; b.alusrc = 0; b.regwrite = 0;
    b.memwrite = 0; b.memtoreg = 0; b.valid = 0;
    return b;
  endfunction

  // Value an instruction reading register idx sees in EX.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regval);
`ifdef EX_FWD_EN
    if (idx == 0) return regval;
    if (RegWriteM && WriteRegM == idx) return ALUOutM;
    if (RegWriteW && WriteRegW == idx) return ResultW;
`endif
    return regval;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] b;
    b = operand(m_e.rt, m_e.rd2);
    check("ALUsel",     {28'd0, ALUsel},    {28'd0, m_e.alusel});
    check("Shamt",      {27'd0, Shamt},     {27'd0, m_e.shamt});
    check("ALUIn1",     ALUIn1,             operand(m_e.rs, m_e.rd1));
    check("ALUIn2",     ALUIn2,             m_e.alusrc ? m_e.imm : b);
    check("WriteDataE", WriteDataE,         b);
    check("WriteRegE",  {27'd0, WriteRegE}, {27'd0, m_e.wreg});
    check("RsE",        {27'd0, RsE},       {27'd0, m_e.rs});
    check("RtE",        {27'd0, RtE},       {27'd0, m_e.rt});
    check("RegWriteE",  {31'd0, RegWriteE}, {31'd0, m_e.regwrite});
    check("MemWriteE",  {31'd0, MemWriteE}, {31'd0, m_e.memwrite});
    check("MemtoRegE",  {31'd0, MemtoRegE}, {31'd0, m_e.memtoreg});
    check("ValidE",     {31'd0, ValidE},    {31'd0, m_e.valid});
  endtask

  // Advance one cycle: model follows the edge, then return at the negedge.
  task automatic tick();
    @(posedge clk);
    if (rst || FlushE) m_e = bubble();
    else if (!StallE) begin
      m_e.rd1 = RD1D; m_e.rd2 = RD2D; m_e.imm = SignImmD;
      m_e.rs = RsD; m_e.rt = RtD; m_e.wreg = WriteRegD;
      m_e.alusel = ALUSelD; m_e.shamt = ShamtD; m_e.alusrc = ALUSrcD;
      m_e.regwrite = RegWriteD; m_e.memwrite = MemWriteD;
      m_e.memtoreg = MemtoRegD; m_e.valid = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic clear_mw();
    ALUOutM = 0; WriteRegM = 0; RegWriteM = 0;
    ResultW = 0; WriteRegW = 0; RegWriteW = 0;
  endtask

  task automatic clear_d();
    RD1D = 0; RD2D = 0; SignImmD = 0; RsD = 0; RtD = 0; WriteRegD = 0;
    ALUSelD = 0; ShamtD = 0; ALUSrcD = 0;
    RegWriteD = 0; MemWriteD = 0; MemtoRegD = 0;
  endtask

  task automatic randomize_inputs();
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
    RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
    WriteRegD = 5'($urandom); ALUSelD = 4'($urandom_range(0, 10));
    ShamtD = 5'($urandom); ALUSrcD = 1'($urandom);
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); MemtoRegD = 1'($urandom);
    ALUOutM = $urandom; ResultW = $urandom;
    WriteRegM = 5'($urandom_range(0, 3)); WriteRegW = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    rst    = ($urandom_range(0, 31) == 0);
    FlushE = ($urandom_range(0, 7) == 0);
    StallE = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    m_e = bubble();
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    clear_d(); clear_mw();
    @(negedge clk);

    // Reset clears every E register.
    tick();
    #1;
    check("rst_ValidE", {31'd0, ValidE}, 32'd0);
    check("rst_ALUsel", {28'd0, ALUsel}, 32'd0);
    check_all();

    // First load after reset.
    rst = 1'b0; RD1D = 5; RD2D = 7;
    tick();
    #1;
    check("load_ALUIn1", ALUIn1, 32'd5);
    check("load_ALUIn2", ALUIn2, 32'd7);
    check("load_ValidE", {31'd0, ValidE}, 32'd1);
    check_all();

    // MEM has priority over WB.
    RsD = 3; RD1D = 32'h55;
    tick();
    WriteRegM = 3; RegWriteM = 1; ALUOutM = 32'h11;
    WriteRegW = 3; RegWriteW = 1; ResultW = 32'h22;
    #1;
`ifdef EX_FWD_EN
    check("fwd_m_over_w", ALUIn1, 32'h11);
`else
    check("nofwd_m_w", ALUIn1, 32'h55);
`endif
    check_all();
    RegWriteM = 0;
    #1;
`ifdef EX_FWD_EN
    check("fwd_w", ALUIn1, 32'h22);
`else
    check("nofwd_w", ALUIn1, 32'h55);
`endif
    check_all();
    clear_mw();

    // Register 0 is never forwarded.
    RtD = 0; RD2D = 0; ALUSrcD = 0;
    tick();
    WriteRegM = 0; RegWriteM = 1; ALUOutM = 32'hFF;
    #1;
    check("r0_ALUIn2", ALUIn2, 32'd0);
    check("r0_WriteDataE", WriteDataE, 32'd0);
    clear_mw();

    // Immediate goes to the ALU while store data takes forwarded rt.
    ALUSrcD = 1; SignImmD = 32'hFFFF_FFFC; RtD = 4; RD2D = 32'h33;
    tick();
    WriteRegW = 4; RegWriteW = 1; ResultW = 9;
    #1;
    check("imm_ALUIn2", ALUIn2, 32'hFFFF_FFFC);
`ifdef EX_FWD_EN
    check("imm_WriteDataE", WriteDataE, 32'd9);
`else
    check("imm_WriteDataE", WriteDataE, 32'h33);
`endif
    check_all();
    clear_mw();

    // Stall holds through changing D inputs, then flush wins over stall.
    clear_d(); ALUSelD = 2; ShamtD = 4; RegWriteD = 1;
    tick();
    StallE = 1;
    for (int i = 0; i < 2; i++) begin
      ALUSelD = 4'(5 + i); ShamtD = 5'(9 + i); RD1D = $urandom;
      tick();
    end
    #1;
    check("stall_ALUsel", {28'd0, ALUsel}, 32'd2);
    check("stall_Shamt", {27'd0, Shamt}, 32'd4);
    check_all();
    FlushE = 1;
    tick();
    #1;
    check("flush_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    check("flush_ValidE", {31'd0, ValidE}, 32'd0);
    check("flush_ALUsel", {28'd0, ALUsel}, 32'd0);
    check_all();

    // Reset during a stall still clears.
    FlushE = 0; StallE = 0; RD1D = 32'hABCD; RegWriteD = 1;
    tick();
    StallE = 1; rst = 1;
    tick();
    #1;
    check("rst_stall_ValidE", {31'd0, ValidE}, 32'd0);
    check("rst_stall_ALUIn1", ALUIn1, 32'd0);
    rst = 0; StallE = 0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      #1;
      check_all();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
